// File: rtl/serial_adder_pkg.sv
// Shared types and default sizes for the serial chunk adder.
package serial_adder_pkg;

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned CHUNK_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sadd_state_t;

endpackage

// File: rtl/chunk_adder.sv
// Combinational N-bit ripple-carry adder.
// Also exposes the carry into bit N-1 so the caller can form signed overflow.
module chunk_adder #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         c_msb
);

    logic [N:0] c;

    // One full adder per bit.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < int'(N); i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
    end

    assign cout  = c[N];
    assign c_msb = c[N-1];

endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per cycle through one
// ripple chunk adder, with valid/ready handshakes on operands and result.
module serial_chunk_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CHUNK = CHUNK_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned NCHUNK = (CHUNK >= 1) ? WIDTH / CHUNK : 1;
    localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    generate
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("serial_chunk_adder: WIDTH must be a nonzero multiple of CHUNK");
        end
    endgenerate

    sadd_state_t      state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;

    logic [CHUNK-1:0] ch_s;
    logic             ch_cout;
    logic             ch_cmsb;
    logic             last_chunk;

    chunk_adder #(.N(CHUNK)) u_chunk (
        .a     (a_r[CHUNK-1:0]),
        .b     (b_r[CHUNK-1:0]),
        .cin   (carry),
        .s     (ch_s),
        .cout  (ch_cout),
        .c_msb (ch_cmsb)
    );

    assign last_chunk = (count == CW'(NCHUNK - 1));

    // Control, operand shifting and result accumulation.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            carry  <= 1'b0;
            count  <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        count <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // New chunk enters at the top; after NCHUNK cycles it is aligned.
                    sum_r <= (sum_r >> CHUNK) | (WIDTH'(ch_s) << (WIDTH - CHUNK));
                    a_r   <= a_r >> CHUNK;
                    b_r   <= b_r >> CHUNK;
                    carry <= ch_cout;
                    if (last_chunk) begin
                        cout_r <= ch_cout;
                        ovf_r  <= ch_cmsb ^ ch_cout;
                        state  <= DONE;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Directed bench for serial_chunk_adder: main 16/4 instance plus 16/16 and 16/1.
module tb_serial_chunk_adder;

    logic        clk = 1'b0;
    logic        reset_n;

    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, busy;
    logic [15:0] a, b, sum;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_cout, w_ovf, w_busy;
    logic [15:0] w_a, w_b, w_sum;

    logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_cout, n_ovf, n_busy;
    logic [15:0] n_a, n_b, n_sum;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );

    serial_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut_wide (
        .clk(clk), .reset_n(reset_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .a(w_a), .b(w_b), .cin(1'b0), .sub(1'b0), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .sum(w_sum), .cout(w_cout), .ovf(w_ovf), .busy(w_busy)
    );

    serial_chunk_adder #(.WIDTH(16), .CHUNK(1)) dut_narrow (
        .clk(clk), .reset_n(reset_n), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .a(n_a), .b(n_b), .cin(1'b0), .sub(1'b0), .out_valid(n_out_valid), .out_ready(n_out_ready),
        .sum(n_sum), .cout(n_cout), .ovf(n_ovf), .busy(n_busy)
    );

    // Present operands for one edge, then count edges until out_valid (bounded).
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                          input logic ts, output int lat);
        a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if ({sum, cout, ovf} !== 18'h0) begin bad++; $display("FAIL reset_outputs got=%h/%b/%b exp=0000/0/0", sum, cout, ovf); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        int lat;
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL add_latency got=%0d exp=4", lat); end
        total++; if ({sum, cout, ovf} !== {16'h2345, 1'b0, 1'b0}) begin bad++; $display("FAIL add_basic got=%h/%b/%b exp=2345/0/0", sum, cout, ovf); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL add_busy_done got=%b exp=1", busy); end
        release_result();
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
        total++; if ({sum, cout, ovf} !== {16'h0000, 1'b1, 1'b0}) begin bad++; $display("FAIL add_full_carry got=%h/%b/%b exp=0000/1/0", sum, cout, ovf); end
        release_result();
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
        total++; if ({sum, cout, ovf} !== {16'h8000, 1'b0, 1'b1}) begin bad++; $display("FAIL add_overflow got=%h/%b/%b exp=8000/0/1", sum, cout, ovf); end
        release_result();
        run_op(16'h00FF, 16'h0100, 1'b1, 1'b0, lat);
        total++; if ({sum, cout, ovf} !== {16'h0200, 1'b0, 1'b0}) begin bad++; $display("FAIL add_cin got=%h/%b/%b exp=0200/0/0", sum, cout, ovf); end
        release_result();
    endtask

    task automatic test_sub();
        int lat;
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, lat);
        total++; if ({sum, cout, ovf} !== {16'hFFFE, 1'b0, 1'b0}) begin bad++; $display("FAIL sub_borrow got=%h/%b/%b exp=fffe/0/0", sum, cout, ovf); end
        release_result();
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, lat);
        total++; if ({sum, cout, ovf} !== {16'h7FFF, 1'b1, 1'b1}) begin bad++; $display("FAIL sub_overflow got=%h/%b/%b exp=7fff/1/1", sum, cout, ovf); end
        release_result();
    endtask

    task automatic test_backpressure();
        int lat;
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, lat);
        a = 16'hAAAA; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++; if ({out_valid, in_ready, sum, cout, ovf} !== {1'b1, 1'b0, 16'h2345, 1'b0, 1'b0})
                begin bad++; $display("FAIL bp_hold_%0d got v=%b r=%b %h/%b/%b exp v=1 r=0 2345/0/0", i, out_valid, in_ready, sum, cout, ovf); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("FAIL bp_release got r=%b v=%b exp r=1 v=0", in_ready, out_valid); end
        total++; if (sum !== 16'h2345) begin bad++; $display("FAIL bp_sum_kept got=%h exp=2345", sum); end
        run_op(16'hAAAA, 16'h1111, 1'b0, 1'b0, lat);
        total++; if ({sum, cout, ovf} !== {16'hBBBB, 1'b0, 1'b0}) begin bad++; $display("FAIL bp_next_op got=%h/%b/%b exp=bbbb/0/0", sum, cout, ovf); end
        release_result();
    endtask

    task automatic test_reset_midrun();
        int lat;
        a = 16'h4321; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        total++; if ({in_ready, out_valid, busy} !== 3'b100) begin bad++; $display("FAIL midrun_state got r=%b v=%b busy=%b exp 1/0/0", in_ready, out_valid, busy); end
        total++; if (sum !== 16'h0000) begin bad++; $display("FAIL midrun_sum got=%h exp=0000", sum); end
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, lat);
        total++; if ({sum, cout, ovf} !== {16'h0002, 1'b0, 1'b0} || lat !== 4)
            begin bad++; $display("FAIL midrun_after got=%h/%b/%b lat=%0d exp=0002/0/0 lat=4", sum, cout, ovf, lat); end
        release_result();
    endtask

    task automatic test_param_sweep();
        int lw, ln;
        w_a = 16'hFFFF; w_b = 16'h0001; w_in_valid = 1'b1;
        n_a = 16'hFFFF; n_b = 16'h0001; n_in_valid = 1'b1;
        @(posedge clk); #1;
        w_in_valid = 1'b0; n_in_valid = 1'b0;
        lw = -1; ln = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (w_out_valid && lw < 0) lw = k;
            if (n_out_valid && ln < 0) ln = k;
        end
        total++; if (lw !== 1) begin bad++; $display("FAIL wide_latency got=%0d exp=1", lw); end
        total++; if ({w_sum, w_cout} !== {16'h0000, 1'b1}) begin bad++; $display("FAIL wide_result got=%h/%b exp=0000/1", w_sum, w_cout); end
        total++; if (ln !== 16) begin bad++; $display("FAIL narrow_latency got=%0d exp=16", ln); end
        total++; if ({n_sum, n_cout, n_ovf} !== {16'h0000, 1'b1, 1'b0}) begin bad++; $display("FAIL narrow_result got=%h/%b/%b exp=0000/1/0", n_sum, n_cout, n_ovf); end
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        w_in_valid = 1'b0; w_out_ready = 1'b0; w_a = '0; w_b = '0;
        n_in_valid = 1'b0; n_out_ready = 1'b0; n_a = '0; n_b = '0;
        #1;
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_reset_midrun();
        test_param_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
